// File: rtl/idli_sqi_sram_m.sv
// SQI SRAM responder: decodes READ/WRITE commands nibble by nibble and
// streams bytes to or from an internal auto-incrementing byte array.
module idli_sqi_sram_m #(
   parameter int unsigned DEPTH_BYTES = 1024
) (
   input  logic       i_mem_gck,
   input  logic       i_mem_rst_n,
   input  logic       i_mem_cs,
   input  logic       i_mem_sck,
   input  logic [3:0] i_mem_sio,
   output logic [3:0] o_mem_sio,
   output logic       o_mem_sio_oe
);

   localparam int unsigned AW = $clog2(DEPTH_BYTES);
   localparam int unsigned CW = 3;
   localparam logic [7:0]  CMD_READ  = 8'h03;
   localparam logic [7:0]  CMD_WRITE = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE, ST_ADDR, ST_DUMMY, ST_READ, ST_WRITE, ST_IGNORE
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic            nib_q;
   logic [3:0]      hi_q;
   logic [7:0]      cmd_q;
   logic [AW-1:0]   addr_q;
   logic [7:0]      mem [DEPTH_BYTES];
   logic [7:0]      rd_byte_c;
   logic            beat_c;

   assign beat_c    = !i_mem_cs && i_mem_sck;
   assign rd_byte_c = mem[addr_q];

   // State register
   always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
      if (!i_mem_rst_n) state_q <= ST_IDLE;
      else              state_q <= state_d;
   end

   // Next state: deselect wins over any beat on the same edge
   always_comb begin
      state_d = state_q;
      if (i_mem_cs) begin
         state_d = ST_IDLE;
      end else if (i_mem_sck) begin
         case (state_q)
            ST_IDLE:  if (cnt_q == CW'(1)) state_d = ST_ADDR;
            ST_ADDR: begin
               if (cnt_q == CW'(5)) begin
                  if (cmd_q == CMD_READ)       state_d = ST_DUMMY;
                  else if (cmd_q == CMD_WRITE) state_d = ST_WRITE;
                  else                         state_d = ST_IGNORE;
               end
            end
            ST_DUMMY: if (cnt_q == CW'(1)) state_d = ST_READ;
            default:  state_d = state_q;
         endcase
      end
   end

   // Outputs: read data is a live view of the current address and nibble flag
   always_comb begin
      o_mem_sio_oe = 1'b0;
      o_mem_sio    = 4'd0;
      if (state_q == ST_READ) begin
         o_mem_sio_oe = 1'b1;
         o_mem_sio    = nib_q ? rd_byte_c[3:0] : rd_byte_c[7:4];
      end
   end

   // Beat counter, command/address capture and streaming address
   always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
      if (!i_mem_rst_n) begin
         cnt_q  <= '0;
         nib_q  <= 1'b0;
         hi_q   <= 4'd0;
         cmd_q  <= 8'd0;
         addr_q <= '0;
      end else if (i_mem_cs) begin
         cnt_q <= '0;
         nib_q <= 1'b0;
         hi_q  <= 4'd0;
      end else if (i_mem_sck) begin
         cnt_q <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
         case (state_q)
            ST_IDLE: cmd_q  <= {cmd_q[3:0], i_mem_sio};
            ST_ADDR: addr_q <= AW'({addr_q, i_mem_sio});
            ST_READ: begin
               nib_q <= !nib_q;
               if (nib_q) addr_q <= addr_q + AW'(1);
            end
            ST_WRITE: begin
               nib_q <= !nib_q;
               if (!nib_q) hi_q   <= i_mem_sio;
               else        addr_q <= addr_q + AW'(1);
            end
            default: ;
         endcase
      end
   end

   // Byte array, deliberately not reset; a reset clears nib_q so no write commits
   always_ff @(posedge i_mem_gck) begin
      if (beat_c && state_q == ST_WRITE && nib_q)
         mem[addr_q] <= {hi_q, i_mem_sio};
   end

endmodule

// File: tb/tb_idli_sqi_sram_m.sv
// Self-checking bench for idli_sqi_sram_m against a flat byte-array model.
module tb_idli_sqi_sram_m;

   localparam int DEPTH = 1024;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cs;
   logic       sck;
   logic [3:0] sio_in;
   logic [3:0] sio_out;
   logic       sio_oe;

   int checks = 0;
   int failures = 0;
   int oe_err = 0;
   int gap_min = 0;
   int gap_max = 0;

   logic [7:0] mdl [DEPTH];
   logic [7:0] rd_buf [64];
   logic [7:0] wr_buf [64];

   idli_sqi_sram_m #(.DEPTH_BYTES(DEPTH)) dut (
      .i_mem_gck(clk), .i_mem_rst_n(rst_n), .i_mem_cs(cs), .i_mem_sck(sck),
      .i_mem_sio(sio_in), .o_mem_sio(sio_out), .o_mem_sio_oe(sio_oe)
   );

   always #5 clk = ~clk;

   task automatic beat(input logic [3:0] n);
      int g;
      g = $urandom_range(gap_max, gap_min);
      repeat (g) begin @(posedge clk); #1; end
      cs = 1'b0; sck = 1'b1; sio_in = n;
      @(posedge clk); #1;
      sck = 1'b0; sio_in = 4'($urandom);
   endtask

   task automatic deselect();
      cs = 1'b1; sck = 1'($urandom);
      @(posedge clk); #1;
      sck = 1'b0;
      if (sio_oe !== 1'b0) oe_err++;
   endtask

   task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
      beat(cmd[7:4]); if (sio_oe !== 1'b0) oe_err++;
      beat(cmd[3:0]); if (sio_oe !== 1'b0) oe_err++;
      for (int i = 5; i >= 0; i--) begin
         beat(a[i*4 +: 4]);
         if (sio_oe !== 1'b0) oe_err++;
      end
   endtask

   task automatic wr(input logic [23:0] a, input int n);
      hdr(8'h02, a);
      for (int i = 0; i < n; i++) begin
         beat(wr_buf[i][7:4]); if (sio_oe !== 1'b0) oe_err++;
         beat(wr_buf[i][3:0]); if (sio_oe !== 1'b0) oe_err++;
         mdl[(int'(a) + i) % DEPTH] = wr_buf[i];
      end
      deselect();
   endtask

   task automatic rd(input logic [23:0] a, input int n);
      logic [7:0] b;
      hdr(8'h03, a);
      for (int i = 0; i < 2; i++) begin
         if (sio_oe !== 1'b0) oe_err++;
         beat(4'($urandom));
      end
      for (int i = 0; i < n; i++) begin
         if (sio_oe !== 1'b1) oe_err++;
         b[7:4] = sio_out;
         beat(4'($urandom));
         if (sio_oe !== 1'b1) oe_err++;
         b[3:0] = sio_out;
         beat(4'($urandom));
         rd_buf[i] = b;
      end
      deselect();
   endtask

   task automatic test_reset();
      checks++;
      if (sio_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", sio_oe); end
      checks++;
      if (sio_out !== 4'h0) begin failures++; $display("FAIL reset_sio got=%h exp=0", sio_out); end
   endtask

   task automatic test_write_read();
      logic [23:0] a;
      int n;
      oe_err = 0;
      wr_buf[0] = 8'hA5; wr_buf[1] = 8'h3C;
      wr(24'h000010, 2);
      rd(24'h000010, 2);
      checks++;
      if (rd_buf[0] !== 8'hA5) begin failures++; $display("FAIL wr_rd_b0 got=%h exp=a5", rd_buf[0]); end
      checks++;
      if (rd_buf[1] !== 8'h3C) begin failures++; $display("FAIL wr_rd_b1 got=%h exp=3c", rd_buf[1]); end
      for (int it = 0; it < 6; it++) begin
         a = 24'($urandom);
         n = $urandom_range(8, 1);
         for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
         wr(a, n);
         rd(a, n);
         for (int i = 0; i < n; i++) begin
            checks++;
            if (rd_buf[i] !== mdl[(int'(a) + i) % DEPTH]) begin
               failures++;
               $display("FAIL rand_rd a=%h i=%0d got=%h exp=%h", a, i, rd_buf[i], mdl[(int'(a) + i) % DEPTH]);
            end
         end
      end
      checks++;
      if (oe_err !== 0) begin failures++; $display("FAIL wr_rd_oe errors=%0d exp=0", oe_err); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] prior;
      oe_err = 0;
      hdr(8'h03, 24'h000010);
      beat(4'h0); beat(4'h0);
      checks++;
      if (sio_oe !== 1'b1) begin failures++; $display("FAIL pre_rst_oe got=%b exp=1", sio_oe); end
      rst_n = 1'b0; #1;
      checks++;
      if (sio_oe !== 1'b0) begin failures++; $display("FAIL mid_rst_oe got=%b exp=0", sio_oe); end
      @(posedge clk); #1;
      rst_n = 1'b1; cs = 1'b1;
      rd(24'h000010, 2);
      checks++;
      if (rd_buf[0] !== mdl[16] || rd_buf[1] !== mdl[17]) begin
         failures++;
         $display("FAIL post_rst_rd got=%h%h exp=%h%h", rd_buf[0], rd_buf[1], mdl[16], mdl[17]);
      end
      wr_buf[0] = 8'($urandom);
      wr(24'h000030, 1);
      prior = mdl[8'h30];
      hdr(8'h02, 24'h000030);
      beat(~prior[7:4]);
      cs = 1'b0; sck = 1'b1; sio_in = ~prior[3:0]; rst_n = 1'b0;
      @(posedge clk); #1;
      sck = 1'b0; cs = 1'b1; rst_n = 1'b1;
      rd(24'h000030, 1);
      checks++;
      if (rd_buf[0] !== prior) begin failures++; $display("FAIL rst_no_write got=%h exp=%h", rd_buf[0], prior); end
      checks++;
      if (oe_err !== 0) begin failures++; $display("FAIL rst_oe errors=%0d exp=0", oe_err); end
   endtask

   task automatic test_wrap();
      oe_err = 0;
      wr_buf[0] = 8'h11; wr_buf[1] = 8'h22;
      wr(24'h0003FF, 2);
      rd(24'h0003FF, 2);
      checks++;
      if (rd_buf[0] !== 8'h11 || rd_buf[1] !== 8'h22) begin
         failures++; $display("FAIL wrap_rd got=%h%h exp=1122", rd_buf[0], rd_buf[1]);
      end
      rd(24'h000000, 1);
      checks++;
      if (rd_buf[0] !== 8'h22) begin failures++; $display("FAIL wrap_mem0 got=%h exp=22", rd_buf[0]); end
      rd(24'h000400, 1);
      checks++;
      if (rd_buf[0] !== 8'h22) begin failures++; $display("FAIL alias_400 got=%h exp=22", rd_buf[0]); end
      rd(24'hABCBFF, 2);
      checks++;
      if (rd_buf[0] !== 8'h11 || rd_buf[1] !== 8'h22) begin
         failures++; $display("FAIL alias_hi got=%h%h exp=1122", rd_buf[0], rd_buf[1]);
      end
      checks++;
      if (oe_err !== 0) begin failures++; $display("FAIL wrap_oe errors=%0d exp=0", oe_err); end
   endtask

   task automatic test_partial();
      logic [7:0] prior;
      wr_buf[0] = 8'($urandom);
      wr(24'h000021, 1);
      prior = mdl[8'h21];
      hdr(8'h02, 24'h000020);
      beat(4'h7); beat(4'h7); beat(4'h9);
      mdl[8'h20] = 8'h77;
      deselect();
      rd(24'h000020, 2);
      checks++;
      if (rd_buf[0] !== 8'h77) begin failures++; $display("FAIL partial_b0 got=%h exp=77", rd_buf[0]); end
      checks++;
      if (rd_buf[1] !== prior) begin failures++; $display("FAIL partial_b1 got=%h exp=%h", rd_buf[1], prior); end
   endtask

   task automatic test_unknown();
      logic [7:0] cmd;
      for (int it = 0; it < 3; it++) begin
         oe_err = 0;
         if (it == 0) cmd = 8'hEB;
         else begin
            cmd = 8'($urandom);
            if (cmd == 8'h02 || cmd == 8'h03) cmd = 8'hFF;
         end
         hdr(cmd, 24'h000010);
         for (int i = 0; i < 8; i++) begin
            beat(4'($urandom));
            if (sio_oe !== 1'b0) oe_err++;
         end
         deselect();
         checks++;
         if (oe_err !== 0) begin failures++; $display("FAIL unk_oe cmd=%h errors=%0d exp=0", cmd, oe_err); end
         rd(24'h000010, 4);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_buf[i] !== mdl[16 + i]) begin
               failures++; $display("FAIL unk_mem cmd=%h i=%0d got=%h exp=%h", cmd, i, rd_buf[i], mdl[16 + i]);
            end
         end
      end
   endtask

   task automatic test_gaps();
      oe_err = 0;
      gap_min = 3; gap_max = 3;
      rd(24'h000010, 2);
      gap_min = 0; gap_max = 0;
      checks++;
      if (rd_buf[0] !== mdl[16] || rd_buf[1] !== mdl[17]) begin
         failures++; $display("FAIL gaps_rd got=%h%h exp=%h%h", rd_buf[0], rd_buf[1], mdl[16], mdl[17]);
      end
      gap_min = 3; gap_max = 3;
      rd(24'h0003FF, 2);
      gap_min = 0; gap_max = 0;
      checks++;
      if (rd_buf[0] !== mdl[1023] || rd_buf[1] !== mdl[0]) begin
         failures++; $display("FAIL gaps_wrap got=%h%h exp=%h%h", rd_buf[0], rd_buf[1], mdl[1023], mdl[0]);
      end
      checks++;
      if (oe_err !== 0) begin failures++; $display("FAIL gaps_oe errors=%0d exp=0", oe_err); end
   endtask

   task automatic test_deselect_priority();
      oe_err = 0;
      beat(4'h0);
      cs = 1'b1; sck = 1'b1; sio_in = 4'h3;
      @(posedge clk); #1;
      sck = 1'b0;
      rd(24'h000010, 2);
      checks++;
      if (rd_buf[0] !== mdl[16] || rd_buf[1] !== mdl[17]) begin
         failures++; $display("FAIL desel_cmd got=%h%h exp=%h%h", rd_buf[0], rd_buf[1], mdl[16], mdl[17]);
      end
      hdr(8'h03, 24'h000010);
      beat(4'h0); beat(4'h0);
      checks++;
      if (sio_out !== mdl[16][7:4]) begin failures++; $display("FAIL desel_nib got=%h exp=%h", sio_out, mdl[16][7:4]); end
      cs = 1'b1; sck = 1'b1; #1;
      checks++;
      if (sio_oe !== 1'b1) begin failures++; $display("FAIL desel_oe_hold got=%b exp=1", sio_oe); end
      @(posedge clk); #1;
      sck = 1'b0;
      checks++;
      if (sio_oe !== 1'b0) begin failures++; $display("FAIL desel_oe_fall got=%b exp=0", sio_oe); end
      rd(24'h000011, 1);
      checks++;
      if (rd_buf[0] !== mdl[17]) begin failures++; $display("FAIL desel_next got=%h exp=%h", rd_buf[0], mdl[17]); end
      checks++;
      if (oe_err !== 0) begin failures++; $display("FAIL desel_oe errors=%0d exp=0", oe_err); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] a;
      int n;
      int off;
      oe_err = 0;
      gap_min = 0; gap_max = 2;
      for (int it = 0; it < 8; it++) begin
         a = 24'($urandom);
         n = $urandom_range(6, 1);
         for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
         wr(a, n);
         off = $urandom_range(n - 1, 0);
         rd(a + 24'(off), n - off);
         for (int i = 0; i < n - off; i++) begin
            checks++;
            if (rd_buf[i] !== mdl[(int'(a) + off + i) % DEPTH]) begin
               failures++;
               $display("FAIL b2b a=%h i=%0d got=%h exp=%h", a, off + i, rd_buf[i], mdl[(int'(a) + off + i) % DEPTH]);
            end
         end
      end
      gap_min = 0; gap_max = 0;
      checks++;
      if (oe_err !== 0) begin failures++; $display("FAIL b2b_oe errors=%0d exp=0", oe_err); end
   endtask

   initial begin
      rst_n = 1'b0; cs = 1'b1; sck = 1'b0; sio_in = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_write_read();
      test_reset_mid();
      test_wrap();
      test_partial();
      test_unknown();
      test_gaps();
      test_deselect_priority();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
